// File: rtl/instruction_fetch_pkg.sv
// +--------------------------------------------------------------------+
// | instruction_fetch_pkg: shared fetch state encoding and instruction |
// | constants.  Rev 1.0                                                |
// +--------------------------------------------------------------------+
`default_nettype none

package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_t;

  localparam logic [15:0] HALT_WORD_DEFAULT = 16'h0300;
  localparam logic [15:0] NOP_WORD          = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch.sv
// +--------------------------------------------------------------------+
// | instruction_fetch: program counter, ROM read and one-word prefetch |
// | feeding the decoder/sequencer.  Rev 1.0                            |
// +--------------------------------------------------------------------+
`default_nettype none

module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                     PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0,
  parameter logic [15:0]            HALT_WORD    = HALT_WORD_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                program_counter_increment,
  input  logic                pc_load,
  input  logic [PC_WIDTH-1:0] pc_load_value,
  output logic [PC_WIDTH-1:0] rom_addr,
  input  logic [15:0]         rom_rdata,
  output logic [15:0]         current_instruction,
  output logic                instruction_valid,
  output logic [PC_WIDTH-1:0] program_counter,
  output logic                halted
);

  fetch_state_t        state;
  fetch_state_t        state_next;
  logic [PC_WIDTH-1:0] pc_next;
  logic [15:0]         instr_next;
  logic                valid_next;
  logic [PC_WIDTH-1:0] pc_plus1;
  logic [PC_WIDTH-1:0] rd_tag;
  logic                rd_tag_valid;
  logic                prefetch_hit;

  // Wraps naturally at the PC width, so the hit test sees the wrapped address.
  assign pc_plus1     = program_counter + PC_WIDTH'(1);
  assign prefetch_hit = rd_tag_valid && (rd_tag == pc_plus1);
  assign halted       = instruction_valid && (current_instruction == HALT_WORD);

  always_comb begin
    state_next = state;
    pc_next    = program_counter;
    instr_next = current_instruction;
    valid_next = instruction_valid;
    rom_addr   = program_counter;

    case (state)
      ST_FETCH: begin
        valid_next = 1'b0;
        if (pc_load) begin
          pc_next    = pc_load_value;
          state_next = ST_FETCH;
        end else begin
          state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (pc_load) begin
          pc_next    = pc_load_value;
          valid_next = 1'b0;
          state_next = ST_FETCH;
        end else begin
          instr_next = rom_rdata;
          valid_next = 1'b1;
          state_next = ST_VALID;
        end
      end

      ST_VALID: begin
        rom_addr = pc_plus1;
        if (pc_load) begin
          pc_next    = pc_load_value;
          valid_next = 1'b0;
          state_next = ST_FETCH;
        end else if (program_counter_increment) begin
          pc_next = pc_plus1;
          // rom_rdata already holds the next word only when its tag matches.
          if (prefetch_hit) begin
            instr_next = rom_rdata;
          end else begin
            valid_next = 1'b0;
            state_next = ST_FETCH;
          end
        end
      end

      default: begin
        valid_next = 1'b0;
        state_next = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= ST_FETCH;
      program_counter     <= RESET_VECTOR;
      current_instruction <= NOP_WORD;
      instruction_valid   <= 1'b0;
      rd_tag              <= '0;
      rd_tag_valid        <= 1'b0;
    end else begin
      state               <= state_next;
      program_counter     <= pc_next;
      current_instruction <= instr_next;
      instruction_valid   <= valid_next;
      rd_tag              <= rom_addr;
      rd_tag_valid        <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus queues expected
// presentations, a falling-edge monitor pops and compares them.
`default_nettype none

module tb_instruction_fetch;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ins;
    logic        halt;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        program_counter_increment;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic [15:0] rom_addr;
  logic [15:0] rom_rdata;
  logic [15:0] current_instruction;
  logic        instruction_valid;
  logic [15:0] program_counter;
  logic        halted;

  logic [15:0] rom [0:65535];
  exp_t        q[$];
  int          checks = 0;
  int          fails  = 0;
  logic        prev_valid = 1'b0;
  logic [15:0] prev_pc    = 16'h0;

  always #5 clock = ~clock;

  always @(posedge clock) rom_rdata <= rom[rom_addr];

  instruction_fetch dut (
    .clock                     (clock),
    .reset                     (reset),
    .program_counter_increment (program_counter_increment),
    .pc_load                   (pc_load),
    .pc_load_value             (pc_load_value),
    .rom_addr                  (rom_addr),
    .rom_rdata                 (rom_rdata),
    .current_instruction       (current_instruction),
    .instruction_valid         (instruction_valid),
    .program_counter           (program_counter),
    .halted                    (halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!instruction_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic expect_item(input logic [15:0] pc, input logic [15:0] ins, input logic halt);
    exp_t e;
    e.pc = pc; e.ins = ins; e.halt = halt;
    q.push_back(e);
  endtask

  // Monitor: a presentation is a valid cycle whose PC differs from the last shown one.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && instruction_valid && (!prev_valid || program_counter != prev_pc)) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_presentation: got pc 0x%0h instr 0x%0h, expected none",
                 program_counter, current_instruction);
      end else begin
        e = q.pop_front();
        check("present_pc", 32'(program_counter), 32'(e.pc));
        check("present_instr", 32'(current_instruction), 32'(e.ins));
        check("present_halted", 32'(halted), 32'(e.halt));
      end
    end
    prev_valid = instruction_valid && !reset;
    prev_pc    = program_counter;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int guard;
    int drops;

    for (int i = 0; i < 65536; i++) rom[i] = 16'(i) ^ 16'h5A00;
    rom[16'h0000] = 16'h1234;
    rom[16'h0001] = 16'h2345;
    rom[16'h0002] = 16'h3456;
    rom[16'h0003] = 16'h4567;
    rom[16'h0004] = 16'h5678;
    rom[16'h0005] = 16'h0300;
    rom[16'h0010] = 16'h0A10;
    rom[16'h0040] = 16'hC0DE;
    rom[16'hFFFF] = 16'hFFEE;

    reset = 1'b1;
    program_counter_increment = 1'b0;
    pc_load = 1'b0;
    pc_load_value = 16'h0;
    repeat (3) step();
    check("reset_valid", 32'(instruction_valid), 0);
    check("reset_pc", 32'(program_counter), 0);
    check("reset_instr", 32'(current_instruction), 0);
    check("reset_halted", 32'(halted), 0);

    // First fetch after reset
    expect_item(16'h0000, 16'h1234, 1'b0);
    reset = 1'b0;
    wait_valid(n);
    check("reset_latency", 32'(n), 2);

    // Increment held high: A,B,C,D in order
    expect_item(16'h0001, 16'h2345, 1'b0);
    expect_item(16'h0002, 16'h3456, 1'b0);
    expect_item(16'h0003, 16'h4567, 1'b0);
    program_counter_increment = 1'b1;
    guard = 0;
    while (!(instruction_valid && program_counter == 16'h0003) && guard < 40) begin
      step();
      guard++;
    end
    program_counter_increment = 1'b0;
    check("seq_reach_pc3", 32'(program_counter), 3);

    // Warm prefetch: increments spaced by an idle cycle never drop valid
    expect_item(16'h0004, 16'h5678, 1'b0);
    expect_item(16'h0005, 16'h0300, 1'b1);
    drops = 0;
    step();
    repeat (2) begin
      program_counter_increment = 1'b1;
      step();
      program_counter_increment = 1'b0;
      if (!instruction_valid) drops++;
      step();
      if (!instruction_valid) drops++;
    end
    check("prefetch_bubbles", 32'(drops), 0);
    check("halted_at_5", 32'(halted), 1);

    // Jump clears halted
    expect_item(16'h0010, 16'h0A10, 1'b0);
    pc_load = 1'b1;
    pc_load_value = 16'h0010;
    step();
    pc_load = 1'b0;
    check("load10_halted", 32'(halted), 0);
    check("load10_valid", 32'(instruction_valid), 0);
    check("load10_pc", 32'(program_counter), 32'h10);
    wait_valid(n);
    check("load10_latency", 32'(n), 2);

    // Jump overrides a same-cycle increment
    expect_item(16'h0040, 16'hC0DE, 1'b0);
    pc_load = 1'b1;
    program_counter_increment = 1'b1;
    pc_load_value = 16'h0040;
    step();
    pc_load = 1'b0;
    program_counter_increment = 1'b0;
    check("load40_pc", 32'(program_counter), 32'h40);
    check("load40_valid", 32'(instruction_valid), 0);
    wait_valid(n);
    check("load40_latency", 32'(n), 2);
    check("load40_pc_after", 32'(program_counter), 32'h40);

    // Wrap from 0xFFFF to 0x0000 through the prefetch
    expect_item(16'hFFFF, 16'hFFEE, 1'b0);
    pc_load = 1'b1;
    pc_load_value = 16'hFFFF;
    step();
    pc_load = 1'b0;
    wait_valid(n);
    check("loadffff_latency", 32'(n), 2);
    step();
    expect_item(16'h0000, 16'h1234, 1'b0);
    program_counter_increment = 1'b1;
    step();
    program_counter_increment = 1'b0;
    check("wrap_pc", 32'(program_counter), 0);
    check("wrap_no_bubble", 32'(instruction_valid), 1);

    // Reset while in WAIT discards the in-flight word
    pc_load = 1'b1;
    pc_load_value = 16'h0040;
    step();
    pc_load = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("rst_wait_valid", 32'(instruction_valid), 0);
    check("rst_wait_pc", 32'(program_counter), 0);
    expect_item(16'h0000, 16'h1234, 1'b0);
    reset = 1'b0;
    wait_valid(n);
    check("rst_wait_latency", 32'(n), 2);

    repeat (4) step();
    check("scoreboard_drained", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
